// File: rtl/wb_ext_bridge.sv
// Registered Wishbone-classic to core ext_* bridge. One request is held at a time;
// it ends with a single-cycle ack, a single-cycle error on timeout, or silently after an abort.
module wb_ext_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic        ext_valid,
  input  logic        ext_ready,
  output logic        ext_instruction,
  output logic [31:0] ext_address,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  input  logic [31:0] ext_read_data
);

  localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    ERR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          abort_q, abort_d;
  logic          valid_q, valid_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          instr_q, instr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strobe_q, strobe_d;
  logic [31:0]   rdata_q, rdata_d;

  logic aborted;
  logic timeout_hit;
  logic req_start;

  // The current cycle's cyc drop counts as an abort even before the flag is stored.
  assign aborted     = abort_q | ~wbs_cyc_i;
  assign timeout_hit = TO_EN && (timer_q == TMAX);
  assign req_start   = wbs_cyc_i & wbs_stb_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_start) state_d = REQ;
      REQ: begin
        if (ext_ready)        state_d = aborted ? IDLE : ACK;
        else if (timeout_hit) state_d = aborted ? IDLE : ERR;
      end
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d  = timer_q;
    abort_d  = abort_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    rdata_d  = rdata_q;
    valid_d  = (state_d == REQ);
    ack_d    = (state_d == ACK);
    err_d    = (state_d == ERR);
    unique case (state_q)
      IDLE: begin
        if (req_start) begin
          instr_d  = wbs_we_i;
          addr_d   = wbs_adr_i;
          wdata_d  = wbs_dat_i;
          strobe_d = wbs_sel_i;
          abort_d  = 1'b0;
          timer_d  = '0;
        end
      end
      REQ: begin
        abort_d = aborted;
        if (ext_ready && !instr_q) rdata_d = ext_read_data;
        if (!ext_ready && (timer_q != '1)) timer_d = timer_q + TW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q  <= '0;
      abort_q  <= 1'b0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      instr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      rdata_q  <= '0;
    end else begin
      timer_q  <= timer_d;
      abort_q  <= abort_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
    end
  end

  assign wbs_ack_o        = ack_q;
  assign wbs_err_o        = err_q;
  assign wbs_dat_o        = rdata_q;
  assign ext_valid        = valid_q;
  assign ext_instruction  = instr_q;
  assign ext_address      = addr_q;
  assign ext_write_data   = wdata_q;
  assign ext_write_strobe = strobe_q;

endmodule
